// File: rtl/serial_adder.sv
// serial_adder: digit-serial add/sub, DIGIT bits per clock.
// Define SERIAL_ADDER_SUB_EN to enable subtraction.
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             Sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             Ovf
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [WIDTH-1:0] b_in;
  logic             c_in;

`ifdef SERIAL_ADDER_SUB_EN
  assign b_in = Sub ? ~B : B;
  assign c_in = Cin ^ Sub;
`else
  logic unused_sub;
  assign unused_sub = Sub;
  assign b_in = B;
  assign c_in = Cin;
`endif

  logic [DIGIT-1:0] dsum;
  logic [DIGIT:0]   c;
  logic             last;

  assign last = (cnt_q == CW'(N - 1));

  // Ripple the low digit of the operand registers
  always_comb begin
    dsum = '0;
    c    = '0;
    c[0] = carry_q;
    for (int i = 0; i < DIGIT; i++) begin
      dsum[i]  = a_q[i] ^ b_q[i] ^ c[i];
      c[i + 1] = (a_q[i] & b_q[i])
               | (c[i] & (a_q[i] ^ b_q[i]));
    end
  end

  // Next-state: accept, step one digit, hand off
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = A;
          b_d     = b_in;
          carry_d = c_in;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        s_d     = WIDTH'({dsum, s_q} >> DIGIT);
        carry_d = c[DIGIT];
        cnt_d   = cnt_q + CW'(1);
        if (last) begin
          cout_d  = c[DIGIT];
          ovf_d   = c[DIGIT-1] ^ c[DIGIT];
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign S         = s_q;
  assign Cout      = cout_q;
  assign Ovf       = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: random + directed checks of serial_adder
// for DIGIT = 1, 4 and 8 at WIDTH = 8.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] A = '0;
  logic [7:0] B = '0;
  logic       Cin = 1'b0;
  logic       Sub = 1'b0;
  logic       out_ready = 1'b0;

  logic       r1_ir, r1_ov, r1_c, r1_o;
  logic [7:0] r1_s;
  logic       r4_ir, r4_ov, r4_c, r4_o;
  logic [7:0] r4_s;
  logic       r8_ir, r8_ov, r8_c, r8_o;
  logic [7:0] r8_s;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8), .DIGIT(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(r1_ir),
    .A(A), .B(B), .Cin(Cin), .Sub(Sub),
    .out_valid(r1_ov), .out_ready(out_ready),
    .S(r1_s), .Cout(r1_c), .Ovf(r1_o)
  );

  serial_adder #(.WIDTH(8), .DIGIT(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(r4_ir),
    .A(A), .B(B), .Cin(Cin), .Sub(Sub),
    .out_valid(r4_ov), .out_ready(out_ready),
    .S(r4_s), .Cout(r4_c), .Ovf(r4_o)
  );

  serial_adder #(.WIDTH(8), .DIGIT(8)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(r8_ir),
    .A(A), .B(B), .Cin(Cin), .Sub(Sub),
    .out_valid(r8_ov), .out_ready(out_ready),
    .S(r8_s), .Cout(r8_c), .Ovf(r8_o)
  );

  // Reference: {ovf, cout, s} from integer arithmetic
  function automatic logic [9:0] ref_op(
    input logic [7:0] a, input logic [7:0] b,
    input logic ci, input logic sub
  );
    int sr;
    int ur;
    logic [7:0] s;
    logic co, ov;
    logic is_sub;
    is_sub = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    is_sub = sub;
`endif
    if (is_sub) begin
      ur = int'(a) - int'(b) - int'(ci);
      sr = int'($signed(a)) - int'($signed(b)) - int'(ci);
      co = (ur >= 0);
    end else begin
      ur = int'(a) + int'(b) + int'(ci);
      sr = int'($signed(a)) + int'($signed(b)) + int'(ci);
      co = (ur > 255);
    end
    s  = ur[7:0];
    ov = (sr > 127) || (sr < -128);
    return {ov, co, s};
  endfunction

  // Drive one operation; report per-DUT latency in edges
  task automatic do_op(
    input logic [7:0] a, input logic [7:0] b,
    input logic ci, input logic sub,
    output int l1, output int l4, output int l8
  );
    int w;
    l1 = -1; l4 = -1; l8 = -1;
    w = 0;
    while (!(r1_ir && r4_ir && r8_ir) && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    if (w >= 20) begin
      vectors++;
      miscompares++;
      $display("FAIL in_ready_wait: got %b%b%b want 111",
               r1_ir, r4_ir, r8_ir);
    end
    A = a; B = b; Cin = ci; Sub = sub;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk); #1;
      if (l1 < 0 && r1_ov) l1 = i;
      if (l4 < 0 && r4_ov) l4 = i;
      if (l8 < 0 && r8_ov) l8 = i;
    end
  endtask

  task automatic test_reset;
    vectors++;
    if (r1_ir !== 1'b1 || r1_ov !== 1'b0 ||
        r1_s !== 8'h00 || r1_c !== 1'b0 ||
        r1_o !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_d1: ir=%b ov=%b s=%h c=%b o=%b want 1 0 00 0 0",
               r1_ir, r1_ov, r1_s, r1_c, r1_o);
    end
    vectors++;
    if (r4_ir !== 1'b1 || r8_ir !== 1'b1 ||
        r4_ov !== 1'b0 || r8_ov !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_d4d8: ir=%b%b ov=%b%b want 11 00",
               r4_ir, r8_ir, r4_ov, r8_ov);
    end
  endtask

  task automatic test_directed;
    logic [7:0] ta [6] = '{8'h0F, 8'hFF, 8'h7F, 8'hA5, 8'h05, 8'h80};
    logic [7:0] tb [6] = '{8'h01, 8'h01, 8'h00, 8'h5B, 8'h07, 8'h80};
    logic       tc [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic       ts [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [9:0] e;
    int l1, l4, l8;
    for (int k = 0; k < 6; k++) begin
      e = ref_op(ta[k], tb[k], tc[k], ts[k]);
      do_op(ta[k], tb[k], tc[k], ts[k], l1, l4, l8);
      vectors++;
      if ({r1_o, r1_c, r1_s} !== e || l1 !== 8) begin
        miscompares++;
        $display("FAIL dir_d1[%0d]: got o%b c%b s%h lat%0d want o%b c%b s%h lat8",
                 k, r1_o, r1_c, r1_s, l1, e[9], e[8], e[7:0]);
      end
      vectors++;
      if ({r4_o, r4_c, r4_s} !== e || l4 !== 2) begin
        miscompares++;
        $display("FAIL dir_d4[%0d]: got o%b c%b s%h lat%0d want o%b c%b s%h lat2",
                 k, r4_o, r4_c, r4_s, l4, e[9], e[8], e[7:0]);
      end
      vectors++;
      if ({r8_o, r8_c, r8_s} !== e || l8 !== 1) begin
        miscompares++;
        $display("FAIL dir_d8[%0d]: got o%b c%b s%h lat%0d want o%b c%b s%h lat1",
                 k, r8_o, r8_c, r8_s, l8, e[9], e[8], e[7:0]);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      vectors++;
      if (r1_ov !== 1'b0 || r1_ir !== 1'b1) begin
        miscompares++;
        $display("FAIL dir_release[%0d]: ov=%b ir=%b want 0 1",
                 k, r1_ov, r1_ir);
      end
    end
  endtask

  task automatic test_backpressure;
    logic [9:0] e;
    int l1, l4, l8;
    e = ref_op(8'h3C, 8'h99, 1'b1, 1'b0);
    do_op(8'h3C, 8'h99, 1'b1, 1'b0, l1, l4, l8);
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'($urandom);
      A = 8'($urandom);
      @(posedge clk); #1;
      vectors++;
      if ({r1_o, r1_c, r1_s} !== e || r1_ir !== 1'b0 ||
          r1_ov !== 1'b1) begin
        miscompares++;
        $display("FAIL bp_hold[%0d]: got o%b c%b s%h ir%b ov%b want o%b c%b s%h ir0 ov1",
                 k, r1_o, r1_c, r1_s, r1_ir, r1_ov, e[9], e[8], e[7:0]);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    vectors++;
    if (r1_ir !== 1'b1 || r1_ov !== 1'b0 ||
        {r1_o, r1_c, r1_s} !== e) begin
      miscompares++;
      $display("FAIL bp_release: ir%b ov%b s%h want ir1 ov0 s%h",
               r1_ir, r1_ov, r1_s, e[7:0]);
    end
  endtask

  task automatic test_reset_mid_run;
    logic [9:0] e;
    int l1, l4, l8;
    A = 8'h96; B = 8'h2D; Cin = 1'b0; Sub = 1'b0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    vectors++;
    if (r1_ov !== 1'b0 || r1_s !== 8'h00 || r1_ir !== 1'b1 ||
        r1_c !== 1'b0 || r1_o !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset: ov%b s%h ir%b c%b o%b want ov0 s00 ir1 c0 o0",
               r1_ov, r1_s, r1_ir, r1_c, r1_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    e = ref_op(8'h64, 8'h1E, 1'b1, 1'b0);
    do_op(8'h64, 8'h1E, 1'b1, 1'b0, l1, l4, l8);
    vectors++;
    if ({r1_o, r1_c, r1_s} !== e || l1 !== 8) begin
      miscompares++;
      $display("FAIL after_reset: got s%h c%b o%b lat%0d want s%h c%b o%b lat8",
               r1_s, r1_c, r1_o, l1, e[7:0], e[8], e[9]);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_random;
    logic [7:0] a, b;
    logic ci, sb;
    logic [9:0] e;
    int l1, l4, l8;
    for (int k = 0; k < 40; k++) begin
      a  = 8'($urandom);
      b  = 8'($urandom);
      ci = 1'($urandom);
      sb = 1'($urandom);
      e = ref_op(a, b, ci, sb);
      do_op(a, b, ci, sb, l1, l4, l8);
      vectors++;
      if ({r1_o, r1_c, r1_s} !== e || l1 !== 8) begin
        miscompares++;
        $display("FAIL rnd_d1[%0d]: a%h b%h ci%b sub%b got o%b c%b s%h lat%0d want o%b c%b s%h",
                 k, a, b, ci, sb, r1_o, r1_c, r1_s, l1, e[9], e[8], e[7:0]);
      end
      vectors++;
      if ({r4_o, r4_c, r4_s} !== e || l4 !== 2) begin
        miscompares++;
        $display("FAIL rnd_d4[%0d]: got o%b c%b s%h lat%0d want o%b c%b s%h",
                 k, r4_o, r4_c, r4_s, l4, e[9], e[8], e[7:0]);
      end
      vectors++;
      if ({r8_o, r8_c, r8_s} !== e || l8 !== 1) begin
        miscompares++;
        $display("FAIL rnd_d8[%0d]: got o%b c%b s%h lat%0d want o%b c%b s%h",
                 k, r8_o, r8_c, r8_s, l8, e[9], e[8], e[7:0]);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
    end
  endtask

  initial begin
    #12;
    test_reset;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_directed;
    test_backpressure;
    test_reset_mid_run;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
